wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two write-back requesters: port 0 (ALU result) and port 1 (memory load data).
- Drives the write-port 2:1 select for the 5-bit destination and the data-width result muxes.
- Round-robin arbitration with a valid/ready handshake; the winning write is registered toward the register file.
- Sits between the execute/memory stages and the register file.

Parameters:
- AW, 5, destination register address width
- DW, 32, write data width
- CW, 16, width of the saturating conflict counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has a pending write
- req0_addr  input  AW  requester 0 destination register
- req0_data  input  DW  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 has a pending write
- req1_addr  input  AW  requester 1 destination register
- req1_data  input  DW  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- stall  input  1  register file cannot accept a write
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  AW  register-file write address (registered)
- wr_data  output  DW  register-file write data (registered)
- sel  output  1  mux select of the last granted write (0 = req0, 1 = req1), registered
- conflict_cnt  output  CW  count of cycles with both requests valid and not stalled

Behaviour:
- Reset (clk edge with rst_n=0): wr_en=0, wr_addr=0, wr_data=0, sel=0, conflict_cnt=0, last_grant=1, so req0 wins the first tie. Reset applied mid-operation drops any in-flight write; nothing is replayed.
- Handshake: a requester holds valid, addr and data stable until it sees ready=1 in the same cycle. readyX is combinational from the valids, stall and last_grant.
- Grant rules when stall=0:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- At most one readyX is high per cycle. Granting X sets last_grant=X at the clock edge.
- Latency: a grant in cycle N produces wr_en=1 with that requester's addr/data and sel=X in cycle N+1 (one cycle). With no grant, wr_en=0 next cycle and wr_addr/wr_data/sel hold their previous values.
- stall=1:
  - Both readys are 0.
  - wr_en, wr_addr, wr_data and sel hold their current values, so a pending write stays presented.
  - last_grant is unchanged and conflict_cnt does not increment.
- When stall falls, arbitration resumes in that cycle using the unchanged last_grant.
- conflict_cnt increments by 1 on each cycle with req0_valid=1, req1_valid=1 and stall=0. It saturates at 2^CW-1 and never wraps.
- Same addr from both requesters in back-to-back grants: both writes are issued in grant order; no merging.

Optional Feature:
- Macro: WB_ARB_ZERO_FILTER_EN.
- Defined: a request with addr=0 is still granted and acknowledged (readyX=1, last_grant updates). The next cycle, wr_en=0 while wr_addr/wr_data/sel still update, so register 0 is never written.
- Undefined: addr=0 requests are issued normally with wr_en=1; the register file is responsible for protecting r0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then valids=0 -> wr_en=0, conflict_cnt=0, all outputs 0.
- Single request: req1_valid=1, addr=5'd9, data=32'hDEADBEEF -> req1_ready=1 same cycle; next cycle wr_en=1, wr_addr=9, wr_data=32'hDEADBEEF, sel=1.
- Contention: both valid for 4 cycles (req0 addr 3, req1 addr 4) after reset -> grants 0,1,0,1; wr_addr sequence 3,4,3,4; conflict_cnt=4.
- Stall: request granted, then stall=1 for 3 cycles with both valid -> readys=0, wr_en/wr_addr/wr_data held, conflict_cnt unchanged; on stall=0, the requester not last granted wins.
- Saturation (CW=4): 20 consecutive contention cycles -> conflict_cnt stops at 15.
- Zero filter with macro defined: req0_valid=1, addr=0, data=32'h1 -> req0_ready=1; next cycle wr_en=0. Without the macro -> wr_en=1, wr_addr=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req0)
// and load (req1) write-back paths. Optional macro WB_ARB_ZERO_FILTER_EN suppresses writes to r0.
module wb_port_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   input  logic          stall,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          sel,
   output logic [CW-1:0] conflict_cnt
);

   logic          last_grant, last_grant_next;
   logic          wr_en_next, sel_next;
   logic [AW-1:0] wr_addr_next;
   logic [DW-1:0] wr_data_next;
   logic [CW-1:0] conflict_cnt_next;
   logic          grant0, grant1;

   // req0 wins unless req1 is also pending and req0 was the last one served.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!stall) begin
         if (req0_valid && (!req1_valid || last_grant)) grant0 = 1'b1;
         else if (req1_valid)                           grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      last_grant_next   = last_grant;
      wr_en_next        = wr_en;
      wr_addr_next      = wr_addr;
      wr_data_next      = wr_data;
      sel_next          = sel;
      conflict_cnt_next = conflict_cnt;
      // A stall freezes everything so the presented write stays on the port.
      if (!stall) begin
         if (req0_valid && req1_valid && (conflict_cnt != {CW{1'b1}}))
            conflict_cnt_next = conflict_cnt + CW'(1);
         wr_en_next = 1'b0;
         if (grant0 || grant1) begin
            last_grant_next = grant1;
            sel_next        = grant1;
            wr_addr_next    = grant1 ? req1_addr : req0_addr;
            wr_data_next    = grant1 ? req1_data : req0_data;
`ifdef WB_ARB_ZERO_FILTER_EN
            wr_en_next      = (wr_addr_next != '0);
`else
            wr_en_next      = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         last_grant   <= 1'b1;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         sel          <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         last_grant   <= last_grant_next;
         wr_en        <= wr_en_next;
         wr_addr      <= wr_addr_next;
         wr_data      <= wr_data_next;
         sel          <= sel_next;
         conflict_cnt <= conflict_cnt_next;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a behavioural model checked every falling edge.
// Built with CW=4 so counter saturation is reachable quickly.
module tb_wb_port_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid, stall;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          wr_en, sel;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [CW-1:0] conflict_cnt;

   wb_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sel(sel),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
   endtask

   // Model: who is owed the port, how many contended cycles happened, what write is presented.
   bit      m_active = 1'b0;
   int      m_last;
   int      m_conflicts;
   bit      m_wr_en;
   int      m_sel;
   int      m_addr;
   int      m_data;

   function automatic int winner();
      if (stall) return -1;
      if (req0_valid && req1_valid) return 1 - m_last;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      int w;
      if (!rst_n) begin
         m_active = 1'b1;
         m_last = 1; m_conflicts = 0; m_wr_en = 1'b0; m_sel = 0; m_addr = 0; m_data = 0;
      end else if (m_active && !stall) begin
         w = winner();
         if (req0_valid && req1_valid) m_conflicts++;
         m_wr_en = 1'b0;
         if (w >= 0) begin
            m_last = w;
            m_sel  = w;
            m_addr = (w == 0) ? int'(req0_addr) : int'(req1_addr);
            m_data = (w == 0) ? int'(req0_data) : int'(req1_data);
`ifdef WB_ARB_ZERO_FILTER_EN
            m_wr_en = (m_addr != 0);
`else
            m_wr_en = 1'b1;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (m_active) begin
         check("m_req0_ready", 32'(req0_ready), 32'(winner() == 0));
         check("m_req1_ready", 32'(req1_ready), 32'(winner() == 1));
         check("m_wr_en",      32'(wr_en),      32'(m_wr_en));
         check("m_wr_addr",    32'(wr_addr),    32'(m_addr));
         check("m_wr_data",    wr_data,         32'(m_data));
         check("m_sel",        32'(sel),        32'(m_sel));
         check("m_conflict",   32'(conflict_cnt), 32'((m_conflicts > CMAX) ? CMAX : m_conflicts));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic st);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      stall = st;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_conflict", 32'(conflict_cnt), 32'd0);
      tick();
      check("idle_wr_en", 32'(wr_en), 32'd0);

      // Single request from the load path.
      drive(1'b0, '0, '0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0);
      #1;
      check("single_req1_ready", 32'(req1_ready), 32'd1);
      check("single_req0_ready", 32'(req0_ready), 32'd0);
      tick();
      idle();
      check("single_wr_en", 32'(wr_en), 32'd1);
      check("single_wr_addr", 32'(wr_addr), 32'd9);
      check("single_wr_data", wr_data, 32'hDEADBEEF);
      check("single_sel", 32'(sel), 32'd1);
      tick();
      check("single_drop_wr_en", 32'(wr_en), 32'd0);
      check("single_hold_addr", 32'(wr_addr), 32'd9);

      // Contention: alternating grants starting with req0.
      do_reset();
      drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
         tick();
         check("cont_wr_addr", 32'(wr_addr), (i % 2 == 0) ? 32'd3 : 32'd4);
      end
      idle();
      check("cont_conflict", 32'(conflict_cnt), 32'd4);

      // Stall holds the presented write; afterwards req1 is owed the port.
      do_reset();
      drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b0);
      #1;
      check("stall_pre_ready0", 32'(req0_ready), 32'd1);
      tick();
      check("stall_pre_addr", 32'(wr_addr), 32'd3);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
         tick();
         check("stall_hold_en", 32'(wr_en), 32'd1);
         check("stall_hold_addr", 32'(wr_addr), 32'd3);
         check("stall_hold_cnt", 32'(conflict_cnt), 32'd1);
      end
      stall = 1'b0;
      #1;
      check("unstall_ready1", 32'(req1_ready), 32'd1);
      tick();
      idle();
      check("unstall_addr", 32'(wr_addr), 32'd4);
      check("unstall_sel", 32'(sel), 32'd1);
      check("unstall_cnt", 32'(conflict_cnt), 32'd2);

      // Reset with a write in flight drops it.
      drive(1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 1'b0);
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_wr_en", 32'(wr_en), 32'd0);
      check("midrst_wr_addr", 32'(wr_addr), 32'd0);

      // Same destination from both: two writes in grant order.
      drive(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'hBBBB_0000, 1'b0);
      tick();
      check("same_first", wr_data, 32'hAAAA_0000);
      tick();
      idle();
      check("same_second", wr_data, 32'hBBBB_0000);
      check("same_addr", 32'(wr_addr), 32'd7);
      tick();

      // Counter saturates at 2^CW-1.
      do_reset();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0);
      repeat (20) tick();
      idle();
      check("sat_conflict", 32'(conflict_cnt), 32'(CMAX));

      // Write to r0.
      do_reset();
      drive(1'b1, 5'd0, 32'h1, 1'b0, '0, '0, 1'b0);
      #1;
      check("zero_ready0", 32'(req0_ready), 32'd1);
      tick();
      idle();
`ifdef WB_ARB_ZERO_FILTER_EN
      check("zero_wr_en", 32'(wr_en), 32'd0);
`else
      check("zero_wr_en", 32'(wr_en), 32'd1);
`endif
      check("zero_wr_addr", 32'(wr_addr), 32'd0);
      check("zero_wr_data", wr_data, 32'h1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
